// File: rtl/sdram_arbit.sv
// sdram_arbit: grants one SDRAM operation at a time among refresh, write and read.
// The command/bank/address pins come from whichever sub-module owns the bus.
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   init_*                   - power-up init status and pin values
//   aref_req/end/cmd/ba/addr - auto-refresh request, done pulse and pin values
//   wr_req/end/cmd/ba/addr   - write request, done pulse and pin values
//   wr_sdram_en/data         - write data and its DQ drive enable
//   rd_req/end/cmd/ba/addr   - read request, done pulse and pin values
//   aref_en, wr_en, rd_en    - registered grants, mutually exclusive
//   sdram_*                  - SDRAM pins; sdram_dq is tri-stated unless writing
module sdram_arbit #(
    parameter logic [3:0]  CMD_NOP = 4'b0111,
    parameter int unsigned DQ_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [12:0]       init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [12:0]       aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [12:0]       wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [12:0]       rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [12:0]       sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq
);

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned ADDR_W = 13;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t              state;
    logic [CMD_W-1:0]    cmd;
    logic [BA_W-1:0]     ba;
    logic [ADDR_W-1:0]   addr;

    // State and grants; requests are only sampled in ARBIT, and each operation
    // returns to ARBIT so at least one NOP cycle separates operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_end) state <= ARBIT;
                end
                ARBIT: begin
                    if (aref_req) begin
                        state   <= AREF;
                        aref_en <= 1'b1;
                    end else if (wr_req) begin
                        state <= WRITE;
                        wr_en <= 1'b1;
                    end else if (rd_req) begin
                        state <= READ;
                        rd_en <= 1'b1;
                    end
                end
                AREF: begin
                    if (aref_end) begin
                        state   <= ARBIT;
                        aref_en <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_end) begin
                        state <= ARBIT;
                        wr_en <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_end) begin
                        state <= ARBIT;
                        rd_en <= 1'b0;
                    end
                end
                default: begin
                    state   <= INIT;
                    aref_en <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux from the current bus owner; ARBIT parks the bus on NOP.
    always_comb begin
        cmd  = CMD_NOP;
        ba   = BA_W'(2'b11);
        addr = ADDR_W'(13'h1fff);
        case (state)
            INIT: begin
                cmd  = init_cmd;
                ba   = init_ba;
                addr = init_addr;
            end
            AREF: begin
                cmd  = aref_cmd;
                ba   = aref_ba;
                addr = aref_addr;
            end
            WRITE: begin
                cmd  = wr_cmd;
                ba   = wr_ba;
                addr = wr_addr;
            end
            READ: begin
                cmd  = rd_cmd;
                ba   = rd_ba;
                addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_ba   = ba;
    assign sdram_addr = addr;

    // The write sub-module gates its own enable, so DQ follows it in any state.
    assign sdram_dq = wr_sdram_en ? wr_sdram_data : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed scoreboard bench for sdram_arbit.
// Expected grants and pin values are pushed when stimulus is applied and
// popped/compared one cycle later (or immediately for async reset).
module tb_sdram_arbit;

    localparam int unsigned DQ_W = 16;

    // {cmd, ba, addr} pin patterns for each owner
    localparam logic [18:0] P_INIT = {4'b0010, 2'b00, 13'h0400};
    localparam logic [18:0] P_NOP  = {4'b0111, 2'b11, 13'h1fff};
    localparam logic [18:0] P_AREF = {4'b0001, 2'b01, 13'h0111};
    localparam logic [18:0] P_WR   = {4'b0100, 2'b10, 13'h0222};
    localparam logic [18:0] P_RD   = {4'b0101, 2'b00, 13'h0333};

    // {aref_en, wr_en, rd_en}
    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_AREF = 3'b100;
    localparam logic [2:0] G_WR   = 3'b010;
    localparam logic [2:0] G_RD   = 3'b001;

    typedef struct {
        string       tag;
        logic [2:0]  grants;
        logic [18:0] pins;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic init_end;
    logic aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
    logic wr_sdram_en;
    logic [DQ_W-1:0] wr_sdram_data;
    logic aref_en, wr_en, rd_en;
    logic sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    wire  [DQ_W-1:0] sdram_dq;
    logic            tb_dq_en;
    logic [DQ_W-1:0] tb_dq;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    assign sdram_dq = tb_dq_en ? tb_dq : {DQ_W{1'bz}};

    always #5 clk = ~clk;

    sdram_arbit #(.CMD_NOP(4'b0111), .DQ_W(DQ_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_end      (init_end),
        .init_cmd      (P_INIT[18:15]),
        .init_ba       (P_INIT[14:13]),
        .init_addr     (P_INIT[12:0]),
        .aref_req      (aref_req),
        .aref_end      (aref_end),
        .aref_cmd      (P_AREF[18:15]),
        .aref_ba       (P_AREF[14:13]),
        .aref_addr     (P_AREF[12:0]),
        .wr_req        (wr_req),
        .wr_end        (wr_end),
        .wr_cmd        (P_WR[18:15]),
        .wr_ba         (P_WR[14:13]),
        .wr_addr       (P_WR[12:0]),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .rd_req        (rd_req),
        .rd_end        (rd_end),
        .rd_cmd        (P_RD[18:15]),
        .rd_ba         (P_RD[14:13]),
        .rd_addr       (P_RD[12:0]),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .sdram_cke     (sdram_cke),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq      (sdram_dq)
    );

    task automatic push(input string tag, input logic [2:0] g, input logic [18:0] p);
        exp_t e;
        e.tag    = tag;
        e.grants = g;
        e.pins   = p;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t       e;
        logic [2:0]  g_obs;
        logic [18:0] p_obs;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=nonzero");
            return;
        end
        e     = sb.pop_front();
        g_obs = {aref_en, wr_en, rd_en};
        p_obs = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
        checks++;
        assert (g_obs === e.grants) else begin
            errors++;
            $error("FAIL %s_grants observed=%b expected=%b", e.tag, g_obs, e.grants);
        end
        checks++;
        assert (p_obs === e.pins) else begin
            errors++;
            $error("FAIL %s_pins observed=%h expected=%h", e.tag, p_obs, e.pins);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push an expectation for the next edge, take the edge, compare.
    task automatic cycle(input string tag, input logic [2:0] g, input logic [18:0] p);
        push(tag, g, p);
        step();
        pop_check();
    endtask

    initial begin
        rst_n = 1'b0; init_end = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0;
        wr_req = 1'b0; wr_end = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0;
        wr_sdram_en = 1'b0; wr_sdram_data = 16'h0000;
        tb_dq_en = 1'b0; tb_dq = 16'h0000;

        #2;
        push("reset", G_NONE, P_INIT);
        pop_check();
        check16("cke", {15'd0, sdram_cke}, 16'd1);

        step(); step();
        rst_n = 1'b1;
        cycle("init_wait1", G_NONE, P_INIT);
        cycle("init_wait2", G_NONE, P_INIT);

        init_end = 1'b1;
        cycle("to_arbit", G_NONE, P_NOP);
        cycle("arbit_idle", G_NONE, P_NOP);

        // All three requests at once: refresh has top priority.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        cycle("prio_aref", G_AREF, P_AREF);
        cycle("aref_hold", G_AREF, P_AREF);
        aref_end = 1'b1; aref_req = 1'b0;
        cycle("aref_done", G_NONE, P_NOP);
        aref_end = 1'b0;
        cycle("prio_wr", G_WR, P_WR);

        // Refresh request arriving mid-write is not serviced until ARBIT.
        aref_req = 1'b1;
        cycle("wr_hold_aref", G_WR, P_WR);

        // DQ: DUT drives when enabled, otherwise the bench can drive freely.
        wr_sdram_en = 1'b1; wr_sdram_data = 16'hA5A5;
        #1;
        check16("dq_drive", sdram_dq, 16'hA5A5);
        wr_sdram_en = 1'b0; tb_dq_en = 1'b1; tb_dq = 16'h1234;
        #1;
        check16("dq_release", sdram_dq, 16'h1234);
        tb_dq_en = 1'b0;

        wr_end = 1'b1; wr_req = 1'b0;
        cycle("wr_done", G_NONE, P_NOP);
        wr_end = 1'b0;
        cycle("aref_after_wr", G_AREF, P_AREF);
        aref_end = 1'b1; aref_req = 1'b0;
        cycle("aref_done2", G_NONE, P_NOP);
        aref_end = 1'b0;
        cycle("rd_grant", G_RD, P_RD);

        // Mismatched end pulses are ignored during READ.
        wr_end = 1'b1; aref_end = 1'b1;
        cycle("rd_spurious", G_RD, P_RD);
        wr_end = 1'b0; aref_end = 1'b0;
        rd_end = 1'b1; rd_req = 1'b0;
        cycle("rd_done", G_NONE, P_NOP);
        rd_end = 1'b0;
        cycle("arbit_idle2", G_NONE, P_NOP);

        // Asynchronous reset in the middle of a write.
        wr_req = 1'b1;
        cycle("wr_grant2", G_WR, P_WR);
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst", G_NONE, P_INIT);
        pop_check();
        wr_req = 1'b0;
        cycle("rst_held", G_NONE, P_INIT);
        rst_n = 1'b1;
        cycle("reinit", G_NONE, P_NOP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Single-clock arbiter sitting directly downstream of the SDRAM read/write FIFO controller.
- Takes the controller's write and read requests, plus the auto-refresh request, and grants exactly one SDRAM operation at a time.
- Drives the SDRAM command, bank, address and DQ pins from whichever sub-module (init, auto-refresh, write, read) currently owns the bus.

Parameters:
- CMD_NOP, 4'b0111, command {cs_n,ras_n,cas_n,we_n} driven while no sub-module owns the bus.
- DQ_W, 16, SDRAM data width.

Ports:
- clk  in  1  system/SDRAM clock
- rst_n  in  1  asynchronous active-low reset
- init_end  in  1  power-up init done; level, stays high
- init_cmd  in  4  init command
- init_ba  in  2  init bank
- init_addr  in  13  init address
- aref_req  in  1  auto-refresh request
- aref_end  in  1  one-cycle pulse, refresh finished
- aref_cmd  in  4  refresh command
- aref_ba  in  2  refresh bank
- aref_addr  in  13  refresh address
- wr_req  in  1  write request from FIFO controller
- wr_end  in  1  one-cycle pulse, write burst finished
- wr_cmd  in  4  write command
- wr_ba  in  2  write bank
- wr_addr  in  13  write address
- wr_sdram_en  in  1  write sub-module drives DQ
- wr_sdram_data  in  DQ_W  write data
- rd_req  in  1  read request from FIFO controller
- rd_end  in  1  one-cycle pulse, read burst finished
- rd_cmd  in  4  read command
- rd_ba  in  2  read bank
- rd_addr  in  13  read address
- aref_en  out  1  grant to refresh sub-module
- wr_en  out  1  grant to write sub-module
- rd_en  out  1  grant to read sub-module
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select
- sdram_ras_n  out  1  row address strobe
- sdram_cas_n  out  1  column address strobe
- sdram_we_n  out  1  write enable
- sdram_ba  out  2  bank address
- sdram_addr  out  13  address pins
- sdram_dq  inout  DQ_W  data bus

Behaviour:
- Reset values:
  - state = INIT; aref_en = wr_en = rd_en = 0.
  - sdram_cke = 1 (constant).
  - Command outputs follow the INIT-state mux.
  - sdram_dq = high-Z.
- FSM states: INIT, ARBIT, AREF, WRITE, READ. State and grants are registered.
- INIT: when init_end = 1, go to ARBIT next cycle.
- ARBIT: fixed priority aref_req > wr_req > rd_req.
  - Winner: next state AREF/WRITE/READ, and the matching *_en is set to 1 on that same edge.
  - No request: stay in ARBIT.
- AREF / WRITE / READ:
  - Hold the grant until the matching *_end pulse.
  - On that edge, clear the grant and return to ARBIT.
  - Every operation is therefore followed by at least one ARBIT (NOP) cycle.
- Requests arriving while an operation is in progress are not latched; they are sampled only in ARBIT. Requesters hold their request level.
- Grants are mutually exclusive; at most one *_en is high in any cycle.
- An *_end pulse that does not match the current state is ignored.
- Command mux (combinational on registered state):
  - INIT → init_*; AREF → aref_*; WRITE → wr_*; READ → rd_*.
  - ARBIT → CMD_NOP, ba = 2'b11, addr = 13'h1fff.
  - {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = selected 4-bit cmd, MSB → cs_n.
- DQ: sdram_dq = wr_sdram_data when wr_sdram_en = 1, else high-Z. wr_sdram_en is honoured in any state (the write sub-module gates it).
- Reset mid-operation: grants drop immediately (async), state → INIT, and init_end must be re-observed.

Test Plan:
- Reset held, then init_end = 1 at cycle 5 → state ARBIT at cycle 6; outputs cmd 4'b0111, ba 2'b11, addr 13'h1fff; all grants 0.
- In ARBIT, aref_req = wr_req = rd_req = 1 in the same cycle → aref_en = 1 next cycle; wr_en = rd_en = 0; sdram cmd follows aref_cmd (e.g. 4'b0001).
- WRITE granted; aref_req rises mid-burst; wr_end at cycle N → wr_en = 0 at N+1, state ARBIT for one cycle; aref_en = 1 at N+2.
- wr_sdram_en = 1 with wr_sdram_data = 16'hA5A5 → sdram_dq reads 16'hA5A5; with wr_sdram_en = 0, a bench-driven 16'h1234 on sdram_dq is seen without contention.
- READ granted; a spurious wr_end pulse arrives → rd_en stays 1; the real rd_end returns the FSM to ARBIT.
- rst_n pulsed low while in WRITE → wr_en = 0 asynchronously; state INIT; init_cmd mirrored on the pins.
